// File: rtl/sd_decimator.sv
// rtl/sd_decimator.sv - sinc3 CIC decimator with 2-entry output FIFO; SD_DECIM_OVERRUN_EN enables the sticky overrun flag
module sd_decimator #(
  parameter int OSR = 32,
  localparam int K = $clog2(OSR),
  localparam int OUT_WIDTH = 3 * K + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic [OUT_WIDTH-1:0] outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 overrun
);

  localparam int W = OUT_WIDTH;
  localparam logic [W-1:0] OFFSET = W'(1) << (3 * K - 1);

  logic [W-1:0] int1, int2, int3;
  logic [K-1:0] cnt;
  logic         dec;

  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] c1, c2, c3;
  logic [W-1:0] comb_out;
  logic         comb_valid;
  logic [1:0]   discard;

  logic [W-1:0] mem [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic         push, pop, full;

  // Integrators wrap modulo 2^W by design; the comb differences recover the exact result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
      cnt  <= '0;
      dec  <= 1'b0;
    end else begin
      dec <= en & (&cnt);
      if (en) begin
        int1 <= int1 + W'(in);
        int2 <= int2 + int1;
        int3 <= int3 + int2;
        cnt  <= cnt + K'(1);
      end
    end
  end

  always_comb begin
    c1 = int3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // The first two comb results see zeroed history and are never pushed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      comb_out   <= '0;
      comb_valid <= 1'b0;
      discard    <= '0;
    end else begin
      comb_valid <= 1'b0;
      if (dec) begin
        d1       <= int3;
        d2       <= c1;
        d3       <= c2;
        comb_out <= c3 - OFFSET;
        if (discard == 2'd2) begin
          comb_valid <= 1'b1;
        end else begin
          discard <= discard + 2'd1;
        end
      end
    end
  end

  assign full     = (count == 2'd2);
  assign pop      = (count != 2'd0) && outReady;
  assign push     = comb_valid && (!full || pop);
  assign outValid = (count != 2'd0);
  assign outData  = mem[rd_ptr];

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot being vacated is refilled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= comb_out;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SD_DECIM_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (comb_valid && full && !pop) begin
      overrun_q <= 1'b1;
    end
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sd_decimator.sv
// tb/tb_sd_decimator.sv - scoreboard bench for sd_decimator at OSR=32
module tb_sd_decimator;

  localparam int OSR = 32;
  localparam int W   = 16;
`ifdef SD_DECIM_OVERRUN_EN
  localparam int OVR_EXP = 1;
`else
  localparam int OVR_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         in = 1'b0;
  logic         outReady = 1'b0;
  logic [W-1:0] outData;
  logic         outValid;
  logic         overrun;

  always #5 clk = ~clk;

  sd_decimator #(.OSR(OSR)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(in),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .overrun(overrun)
  );

  typedef struct {
    int v;
    int t;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   total = 0;
  int   bad = 0;
  int   clk_idx = 0;
  int   en_cnt = 0;
  int   dec_num = 0;
  int   push_budget = -1;
  int   first_valid = -1;
  bit   timing_on = 1'b1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (clk %0d)", name, act, req, clk_idx);
    end
  endtask

  function automatic int exp_val(input int p);
    if (p == 1) return 16384;
    if (p == 0) return -16384;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    in  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clk_idx = 0;
    en_cnt = 0;
    dec_num = 0;
    first_valid = -1;
    sb.delete();
  endtask

  // p: 0 zeros, 1 ones, 2 alternating 1,0; en_mode 1 toggles en starting with 1
  task automatic run(input int n, input int p, input int en_mode, input logic rdy);
    exp_t e;
    bit   ev;
    for (int i = 0; i < n; i++) begin
      outReady = rdy;
      ev = (en_mode == 0) ? 1'b1 : (((clk_idx + 1) % 2) == 1);
      en = ev;
      in = (p == 1) ? 1'b1 : (p == 0) ? 1'b0 : ((en_cnt % 2) == 0);
      @(posedge clk);
      clk_idx++;
      if (ev) begin
        en_cnt++;
        if ((en_cnt % OSR) == 0) begin
          dec_num++;
          if (dec_num >= 3 && push_budget != 0) begin
            e.v = exp_val(p);
            e.t = timing_on ? clk_idx + 2 : -1;
            sb.push_back(e);
            if (push_budget > 0) push_budget--;
          end
        end
      end
      #1;
      if (outValid && first_valid < 0) first_valid = clk_idx;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      outReady = 1'b1;
      en = 1'b0;
      in = 1'b0;
      @(posedge clk);
      clk_idx++;
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst && outValid && outReady) begin
        if (sb.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          m = sb.pop_front();
          check("sample_value", int'($signed(outData)), m.v);
          if (m.t >= 0) check("sample_time", clk_idx, m.t);
        end
      end
    end
  end

  initial begin
    do_reset();
    check("reset_valid", int'(outValid), 0);
    check("reset_data", int'(outData), 0);
    check("reset_overrun", int'(overrun), 0);

    run(8 * OSR, 1, 0, 1'b1);
    check("ones_first_valid", first_valid, 3 * OSR + 2);
    idle(4);
    check("ones_drained", sb.size(), 0);

    do_reset();
    run(6 * OSR, 0, 0, 1'b1);
    check("zeros_first_valid", first_valid, 3 * OSR + 2);
    idle(4);
    check("zeros_drained", sb.size(), 0);

    do_reset();
    run(6 * OSR, 2, 0, 1'b1);
    idle(4);
    check("alt_drained", sb.size(), 0);

    do_reset();
    run(16 * OSR, 1, 1, 1'b1);
    check("entoggle_first_valid", first_valid, 6 * OSR + 1);
    idle(4);
    check("entoggle_drained", sb.size(), 0);

    timing_on = 1'b0;
    do_reset();
    push_budget = 2;
    run(3 * OSR + 2, 1, 0, 1'b0);
    check("bp_first_valid", first_valid, 3 * OSR + 2);
    check("bp_head_data", int'($signed(outData)), 16384);
    run(5 * OSR, 1, 0, 1'b0);
    check("bp_hold_valid", int'(outValid), 1);
    check("bp_hold_data", int'($signed(outData)), 16384);
    check("bp_overrun", int'(overrun), OVR_EXP);
    push_budget = -1;
    idle(2);
    check("bp_empty_after_two", int'(outValid), 0);
    check("bp_drained", sb.size(), 0);
    idle(3);
    check("bp_still_empty", int'(outValid), 0);
    check("bp_overrun_sticky", int'(overrun), OVR_EXP);

    do_reset();
    run(5 * OSR + 1, 1, 0, 1'b0);
    check("simul_full_valid", int'(outValid), 1);
    run(1, 1, 0, 1'b1);
    run(3, 1, 0, 1'b0);
    check("simul_overrun", int'(overrun), 0);
    check("simul_valid", int'(outValid), 1);
    idle(4);
    check("simul_drained", sb.size(), 0);
    check("simul_empty", int'(outValid), 0);

    do_reset();
    push_budget = 2;
    run(180, 1, 0, 1'b0);
    check("pre_rst_overrun", int'(overrun), OVR_EXP);
    run(15, 1, 0, 1'b0);
    do_reset();
    push_budget = -1;
    check("rst_valid", int'(outValid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_data", int'(outData), 0);
    timing_on = 1'b1;
    run(5 * OSR, 1, 0, 1'b1);
    check("rst_first_valid", first_valid, 3 * OSR + 2);
    idle(4);
    check("rst_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
